// File: rtl/roots_pkg.sv
// rtl/roots_pkg.sv - shared types, constants and the binary32 NaN test for roots_requester
package roots_pkg;

  localparam int FP32_W = 32;
  localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fp32_is_nan(input logic [FP32_W-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/roots_watchdog.sv
// rtl/roots_watchdog.sv - WAIT-state timer; expired once TIMEOUT_CYCLES enabled cycles have elapsed
module roots_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  // Counter parks at the limit so it never wraps while the owner lingers.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == 16'(TIMEOUT_CYCLES));

endmodule

// File: rtl/roots_requester.sv
// rtl/roots_requester.sv - issues coefficient triples to a root solver, returns roots or a timeout result
// Optional NaN flagging on res_nan is built when ROOTS_NAN_FLAG_EN is defined.
module roots_requester
  import roots_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FP32_W-1:0] req_a,
  input  logic [FP32_W-1:0] req_b,
  input  logic [FP32_W-1:0] req_c,
  output logic              compute_roots,
  output logic [FP32_W-1:0] a,
  output logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] c,
  input  logic              roots_valid,
  input  logic [FP32_W-1:0] root_1,
  input  logic [FP32_W-1:0] root_2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [FP32_W-1:0] res_root_1,
  output logic [FP32_W-1:0] res_root_2,
  output logic              res_timeout,
  output logic              res_nan,
  output logic [15:0]       timeout_count
);

  state_t state;
  logic   accept;
  logic   expired;

  assign req_ready = (state == IDLE);
  assign accept    = (state == IDLE) && req_valid;

  roots_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state == WAIT),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      compute_roots <= 1'b0;
      a             <= '0;
      b             <= '0;
      c             <= '0;
      res_valid     <= 1'b0;
      res_root_1    <= '0;
      res_root_2    <= '0;
      res_timeout   <= 1'b0;
      timeout_count <= '0;
`ifdef ROOTS_NAN_FLAG_EN
      res_nan       <= 1'b0;
`endif
    end else begin
      compute_roots <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            a             <= req_a;
            b             <= req_b;
            c             <= req_c;
            compute_roots <= 1'b1;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // The pulse cycle is still WAIT; a strobe there cannot belong to this solve.
          if (roots_valid && !compute_roots) begin
            res_root_1  <= root_1;
            res_root_2  <= root_2;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= DONE;
`ifdef ROOTS_NAN_FLAG_EN
            res_nan     <= fp32_is_nan(root_1) || fp32_is_nan(root_2);
`endif
          end else if (expired) begin
            res_root_1  <= FP32_QNAN;
            res_root_2  <= FP32_QNAN;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= DONE;
            if (timeout_count != 16'hFFFF) begin
              timeout_count <= timeout_count + 16'd1;
            end
`ifdef ROOTS_NAN_FLAG_EN
            res_nan     <= 1'b1;
`endif
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ROOTS_NAN_FLAG_EN
  assign res_nan = 1'b0;
`endif

endmodule

// File: tb/tb_roots_requester.sv
// tb/tb_roots_requester.sv - randomized self-checking bench for roots_requester against a timeline model
module tb_roots_requester;

  localparam int T   = 64;
  localparam int BIG = 32'h7FFFFFFF;
`ifdef ROOTS_NAN_FLAG_EN
  localparam bit NANEN = 1'b1;
`else
  localparam bit NANEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req_valid, roots_valid, res_ready;
  logic [31:0] req_a, req_b, req_c, root_1, root_2;
  logic        req_ready, compute_roots, res_valid, res_timeout, res_nan;
  logic [31:0] a, b, c, res_root_1, res_root_2;
  logic [15:0] timeout_count;

  roots_requester #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .compute_roots(compute_roots),
    .a(a), .b(b), .c(c), .roots_valid(roots_valid), .root_1(root_1), .root_2(root_2),
    .res_valid(res_valid), .res_ready(res_ready), .res_root_1(res_root_1),
    .res_root_2(res_root_2), .res_timeout(res_timeout), .res_nan(res_nan),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected behaviour expressed as cycle stamps and the values visible in the current cycle.
  logic [31:0] e_a = 0, e_b = 0, e_c = 0, e_r1 = 0, e_r2 = 0;
  logic        e_to = 0, e_nan = 0;
  int          e_count = 0;
  int          busy_from = BIG, idle_at = 0, done_from = BIG, pulse_at = -1;
  bit          check_en = 0;
  int          n_checks = 0, n_fail = 0;
  int          rise_cyc = -1;
  logic        prev_rv = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_nan(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      check("req_ready", 32'(req_ready), 32'(!(cyc >= busy_from && cyc < idle_at)));
      check("compute_roots", 32'(compute_roots), 32'(cyc == pulse_at));
      check("res_valid", 32'(res_valid), 32'(cyc >= done_from && cyc < idle_at));
      check("a", a, e_a);
      check("b", b, e_b);
      check("c", c, e_c);
      check("res_root_1", res_root_1, e_r1);
      check("res_root_2", res_root_2, e_r2);
      check("res_timeout", 32'(res_timeout), 32'(e_to));
      check("res_nan", 32'(res_nan), 32'(e_nan));
      check("timeout_count", 32'(timeout_count), e_count);
      if (res_valid && !prev_rv) rise_cyc <= cyc;
      prev_rv <= res_valid;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // rv_off: cycles after the pulse at which roots_valid fires (0 or > T means never in the window).
  task automatic do_op(logic [31:0] ia, logic [31:0] ib, logic [31:0] ic, int rv_off,
                       logic [31:0] r1, logic [31:0] r2, int hold);
    int p;
    bit ok;
    p  = cyc + 1;
    ok = (rv_off >= 1 && rv_off <= T);
    req_valid = 1'b1; req_a = ia; req_b = ib; req_c = ic;
    busy_from = cyc + 1; idle_at = BIG; pulse_at = p;
    done_from = ok ? p + rv_off + 1 : p + T + 1;
    nxt();
    e_a = ia; e_b = ib; e_c = ic;
    req_valid = 1'($urandom_range(0, 1)); req_a = $urandom; req_b = $urandom; req_c = $urandom;
    roots_valid = 1'($urandom_range(0, 1)); root_1 = $urandom; root_2 = $urandom;
    for (int j = 1; p + j < done_from; j++) begin
      nxt();
      req_valid = 1'($urandom_range(0, 1)); req_a = $urandom;
      roots_valid = (j == rv_off);
      root_1 = (j == rv_off) ? r1 : $urandom;
      root_2 = (j == rv_off) ? r2 : $urandom;
    end
    nxt();
    e_r1 = ok ? r1 : 32'h7FC00000;
    e_r2 = ok ? r2 : 32'h7FC00000;
    e_to = !ok;
    if (!ok && e_count < 65535) e_count++;
    e_nan = NANEN && (!ok || is_nan(e_r1) || is_nan(e_r2));
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0; req_valid = 1'b1; req_a = $urandom;
      roots_valid = 1'($urandom_range(0, 1)); root_1 = $urandom; root_2 = $urandom;
      nxt();
    end
    res_ready = 1'b1; req_valid = 1'($urandom_range(0, 1)); roots_valid = 1'b0;
    idle_at = cyc + 1;
    nxt();
    res_ready = 1'b0; req_valid = 1'b0;
  endtask

  task automatic rst_in_wait();
    req_valid = 1'b1; req_a = 32'h3F800000; req_b = 32'h40000000; req_c = 32'h40400000;
    busy_from = cyc + 1; idle_at = BIG; pulse_at = cyc + 1; done_from = BIG;
    nxt();
    e_a = 32'h3F800000; e_b = 32'h40000000; e_c = 32'h40400000;
    req_valid = 1'b0;
    repeat (3) nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    e_a = 0; e_b = 0; e_c = 0; e_r1 = 0; e_r2 = 0; e_to = 0; e_nan = 0; e_count = 0;
    idle_at = cyc; pulse_at = -1;
    repeat (5) nxt();
    roots_valid = 1'b1; root_1 = 32'h12345678; root_2 = 32'h9ABCDEF0;
    nxt();
    roots_valid = 1'b0;
    repeat (5) nxt();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; roots_valid = 1'b0; res_ready = 1'b0;
    req_a = 0; req_b = 0; req_c = 0; root_1 = 0; root_2 = 0;
    nxt();
    nxt();
    rst = 1'b0;
    check_en = 1'b1;
    nxt();

    do_op(32'h40400000, 32'hC0000000, 32'hC0A00000, 10, 32'h3FD55555, 32'hBF800000, 0);
    check("lat_success", rise_cyc - pulse_at, 11);
    check("root1_literal", res_root_1, 32'h3FD55555);
    check("root2_literal", res_root_2, 32'hBF800000);

    do_op(32'h40400000, 32'hC0000000, 32'h40A00000, 7, 32'h7FC00000, 32'h7FC00000, 3);
    check("nan_literal", 32'(res_nan), 32'(NANEN));

    do_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 32'h0, 32'h0, 2);
    check("lat_timeout", rise_cyc - pulse_at, 65);
    check("timeout_count_literal", 32'(timeout_count), 1);
    check("timeout_root_literal", res_root_1, 32'h7FC00000);

    do_op(32'h41000000, 32'h40000000, 32'h3F000000, 5, 32'h40800000, 32'hC0800000, 20);

    do_op(32'h40000000, 32'h40000000, 32'h40000000, T, 32'h3E800000, 32'hBE800000, 1);
    check("lat_expiry_edge", rise_cyc - pulse_at, 65);
    check("expiry_no_timeout", 32'(res_timeout), 0);
    check("expiry_count_literal", 32'(timeout_count), 1);

    rst_in_wait();
    check("count_after_rst", 32'(timeout_count), 0);

    for (int i = 0; i < 30; i++) begin
      int off;
      logic [31:0] r1, r2;
      off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 2) : $urandom_range(1, 20);
      r1 = $urandom;
      r2 = ($urandom_range(0, 4) == 0) ? 32'h7F800001 : $urandom;
      do_op($urandom, $urandom, $urandom, off, r1, r2, $urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
